tap_gen2: RTL and testbench
===========================

# tap_gen2

Second-generation IEEE 1149.1 test access port controller. It contains the full 16-state TAP state machine, an instruction register of parametrised width, an internal bypass register and an optional 32-bit IDCODE register. It routes Capture/Shift/Update strobes and TDO selection to N_DR external data-register chains, such as boundary scan and internal scan of the CUT. It sits between the chip test pins and the CUT's scan wrappers.

## Interface
- IR_W, 4: instruction register width; must be ≥ 2 with N_DR ≤ 2^IR_W − 3.
- N_DR, 2: number of external data-register chains.
- IDCODE_OP, 4'hE: opcode selecting IDCODE; must not be all-ones and must be ≥ N_DR.
- IDCODE_VAL, 32'h1000_0001: IDCODE capture value; bit 0 must be 1.

Ports:
- TCK  in  1  test clock; all state changes on rising edge unless stated.
- TRST_b  in  1  asynchronous active-low reset.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out, registered on falling TCK.
- tdo_en  out  1  TDO output-enable, registered on falling TCK.
- dr_tdo  in  N_DR  serial outputs of the external chains.
- dr_sel  out  N_DR  one-hot selected external chain; 0 if none is selected.
- capt_dr  out  N_DR  capture strobe = dr_sel[k] & state==Capture-DR.
- shft_dr  out  N_DR  shift strobe = dr_sel[k] & state==Shift-DR.
- upd_dr  out  N_DR  update strobe = dr_sel[k] & state==Update-DR.
- test_mode  out  1  high whenever state ≠ Test-Logic-Reset.
- inst  out  IR_W  current (updated) instruction.

## Operation
- FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PsDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PsIR, Ex2IR, UpdIR. Transitions follow 1149.1 exactly:
  - TMS=1: TLR→TLR, RTI→SelDR, SelDR→SelIR, SelIR→TLR, Cap→Ex1, Sh→Ex1, Ex1→Upd, Ps→Ex2, Ex2→Upd, Upd→SelDR.
  - TMS=0: TLR→RTI, RTI→RTI, SelDR→CapDR, SelIR→CapIR, Cap→Sh, Sh→Sh, Ex1→Ps, Ps→Ps, Ex2→Sh, Upd→RTI.
- Five consecutive TMS=1 rising edges reach TLR from any state.
- IR shift stage (IR_W bits):
  - CapIR loads {0…0,0,1}: LSB=1, bit1=0.
  - ShIR shifts right, with TDI into the MSB and the LSB going to TDO.
  - The edge leaving UpdIR copies the shift stage to inst.
- Instruction decode:
  - Opcode k < N_DR selects chain k (dr_sel = 1<<k).
  - IDCODE_OP selects IDCODE.
  - All other opcodes, including all-ones, select bypass.
- Bypass: 1 bit; CapDR clears it to 0; ShDR loads TDI.
- IDCODE: 32 bits; CapDR loads IDCODE_VAL; ShDR shifts right with TDI into bit 31.
- TDO source:
  - ShIR: IR LSB.
  - ShDR: LSB of the selected register (dr_tdo[k], IDCODE bit 0, or the bypass bit).
  - All other states: 0.
- In TLR, inst is forced to its reset value on every edge.

## Timing
- TRST_b low: outputs take these values immediately.
  - State = TLR.
  - inst = IDCODE_OP with TAP_IDCODE_EN, all-ones without it.
  - IR shift stage = 0…01.
  - Bypass = 0, IDCODE = IDCODE_VAL.
  - TDO = 0, tdo_en = 0, test_mode = 0.
  - All strobes and dr_sel decoded from the reset inst.
- Strobes (capt/shft/upd_dr) are combinational from registered state and inst. Each is high for the whole TCK period in which the FSM occupies the state. The external chain acts on the rising edge that ends that period.
- TDO and tdo_en change only on falling TCK. tdo_en=1 exactly during ShDR/ShIR. The first bit appears half a cycle after entering Shift.
- Path latency TDI→TDO:
  - Bypass: 1 rising edge.
  - IR: IR_W edges.
  - IDCODE: 32 edges.
- inst changes only on the rising edge leaving UpdIR, or on reset/TLR. dr_sel therefore never changes mid-DR-scan.
- TRST_b asserted mid-scan aborts it. Partially shifted IR content is discarded and inst returns to reset.

## Configuration
- TAP_IDCODE_EN defined:
  - The IDCODE register exists.
  - IDCODE_OP selects it.
  - The reset instruction is IDCODE_OP.
- TAP_IDCODE_EN undefined:
  - No IDCODE register is built.
  - IDCODE_OP decodes as bypass.
  - The reset instruction is all-ones (BYPASS).
  - The IDCODE_VAL parameter is ignored.

## Test plan
- Pulse TRST_b low mid-ShDR → state=TLR, inst=4'hE (macro on) or 4'hF (off), TDO=0, tdo_en=0, test_mode=0, dr_sel=0.
- From ShDR, apply TMS=1 for 5 edges → TLR reached on the 5th edge and held on the 6th; test_mode falls.
- Enter ShIR and shift 4 bits → TDO sequence 1,0,0,0; tdo_en high only during ShIR.
- With IDCODE (macro on): TLR→ShDR, 32 shifts → TDO emits 32'h1000_0001 LSB first. With the macro off, the same sequence → TDO=0 followed by delayed TDI.
- Load IR=4'hF, shift TDI pattern 1,0,1,1,0,0,1,0 in ShDR → TDO = 0,1,0,1,1,0,0,1 (one-bit delay via bypass).
- Load IR=4'h1 → dr_sel=2'b10. capt_dr[1] is high exactly one period in CapDR and upd_dr[1] one period in UpdDR. TDO mirrors dr_tdo[1] during ShDR. capt_dr[0], shft_dr[0] and upd_dr[0] stay 0.

Source files
------------

// File: rtl/tap_gen2_if.sv
// tap_gen2_if: test-pin and scan-chain bundle between the TAP controller and its surroundings.
// Latency: none, wires only.
// Backpressure: none; every signal is a level sampled by TCK.
interface tap_gen2_if #(
  parameter int IR_W = 4,
  parameter int N_DR = 2
);
  logic            TMS;
  logic            TDI;
  logic            TDO;
  logic            tdo_en;
  logic [N_DR-1:0] dr_tdo;
  logic [N_DR-1:0] dr_sel;
  logic [N_DR-1:0] capt_dr;
  logic [N_DR-1:0] shft_dr;
  logic [N_DR-1:0] upd_dr;
  logic            test_mode;
  logic [IR_W-1:0] inst;

  // Pin driver / chain owner side.
  modport master (
    output TMS, TDI, dr_tdo,
    input  TDO, tdo_en, dr_sel, capt_dr, shft_dr, upd_dr, test_mode, inst
  );

  // TAP controller side.
  modport slave (
    input  TMS, TDI, dr_tdo,
    output TDO, tdo_en, dr_sel, capt_dr, shft_dr, upd_dr, test_mode, inst
  );
endinterface

// File: rtl/tap_gen2.sv
// tap_gen2: 1149.1 TAP (16-state FSM, IR, bypass, optional IDCODE when TAP_IDCODE_EN is defined) steering N_DR external chains.
// Latency: TDI->TDO 1 TCK (bypass), IR_W TCK (IR), 32 TCK (IDCODE); TDO/tdo_en launch on falling TCK.
// Backpressure: none; the FSM follows TMS on every rising TCK, external chains act on strobe-qualified rising edges.
module tap_gen2 #(
  parameter int              IR_W       = 4,
  parameter int              N_DR       = 2,
  parameter logic [IR_W-1:0] IDCODE_OP  = 4'hE,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001
) (
  input  logic      TCK,
  input  logic      TRST_b,
  tap_gen2_if.slave tap
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PS_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PS_IR, EX2_IR, UPD_IR
  } state_e;

  // Capture pattern of the IR: LSB=1, bit1=0 so a broken IR path is visible on TDO.
  localparam logic [IR_W-1:0] IR_CAPT = IR_W'(1);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] INST_RST = IDCODE_OP;
`else
  localparam logic [IR_W-1:0] INST_RST = '1;
`endif

  // Illegal parameter combinations; the named scope makes them visible in the elaborated hierarchy.
  if (IR_W < 2 || N_DR < 1 || N_DR > (2**IR_W) - 3 ||
      (&IDCODE_OP) || (IDCODE_OP < N_DR) || !IDCODE_VAL[0]) begin : g_bad_params
  end

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] inst_q, inst_d;
  logic            byp_q, byp_d;
  logic            test_mode_q, test_mode_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;

  logic [N_DR-1:0] dr_sel;
  logic            sel_id;
  logic            sel_byp;
  logic            id_tdo;

  // Next state from TMS; test_mode tracks the state being entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tap.TMS ? TLR    : RTI;
      RTI:    state_d = tap.TMS ? SEL_DR : RTI;
      SEL_DR: state_d = tap.TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tap.TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = tap.TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = tap.TMS ? UPD_DR : PS_DR;
      PS_DR:  state_d = tap.TMS ? EX2_DR : PS_DR;
      EX2_DR: state_d = tap.TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = tap.TMS ? SEL_DR : RTI;
      SEL_IR: state_d = tap.TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = tap.TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = tap.TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = tap.TMS ? UPD_IR : PS_IR;
      PS_IR:  state_d = tap.TMS ? EX2_IR : PS_IR;
      EX2_IR: state_d = tap.TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = tap.TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
    test_mode_d = (state_d != TLR);
  end

  // Instruction decode: low opcodes pick an external chain, IDCODE_OP the ID register, anything else bypass.
  always_comb begin
    dr_sel = '0;
    for (int k = 0; k < N_DR; k++) begin
      if (inst_q == IR_W'(k)) dr_sel[k] = 1'b1;
    end
  end

`ifdef TAP_IDCODE_EN
  assign sel_id = (inst_q == IDCODE_OP);
`else
  assign sel_id = 1'b0;
`endif
  assign sel_byp = ~(|dr_sel) & ~sel_id;

  // IR shift stage: capture the fixed pattern, shift right with TDI entering at the MSB.
  always_comb begin
    ir_d = ir_q;
    if (state_q == CAP_IR) begin
      ir_d = IR_CAPT;
    end else if (state_q == SH_IR) begin
      ir_d = {tap.TDI, ir_q[IR_W-1:1]};
    end
  end

  // Instruction register: reloads its reset value while in TLR, latches the shift stage leaving UpdIR.
  always_comb begin
    inst_d = inst_q;
    if (state_q == TLR) begin
      inst_d = INST_RST;
    end else if (state_q == UPD_IR) begin
      inst_d = ir_q;
    end
  end

  // Bypass bit: cleared on capture, takes TDI on each shift.
  always_comb begin
    byp_d = byp_q;
    if (sel_byp && state_q == CAP_DR) begin
      byp_d = 1'b0;
    end else if (sel_byp && state_q == SH_DR) begin
      byp_d = tap.TDI;
    end
  end

  // Rising-TCK state: FSM, IR stage, instruction, bypass bit and the registered test_mode.
  always_ff @(posedge TCK or negedge TRST_b) begin
    if (!TRST_b) begin
      state_q     <= TLR;
      ir_q        <= IR_CAPT;
      inst_q      <= INST_RST;
      byp_q       <= 1'b0;
      test_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      inst_q      <= inst_d;
      byp_q       <= byp_d;
      test_mode_q <= test_mode_d;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] id_q, id_d;

  // IDCODE register: captures the fixed ID, shifts right with TDI entering bit 31.
  always_comb begin
    id_d = id_q;
    if (sel_id && state_q == CAP_DR) begin
      id_d = IDCODE_VAL;
    end else if (sel_id && state_q == SH_DR) begin
      id_d = {tap.TDI, id_q[31:1]};
    end
  end

  // IDCODE storage on rising TCK.
  always_ff @(posedge TCK or negedge TRST_b) begin
    if (!TRST_b) begin
      id_q <= IDCODE_VAL;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_tdo = id_q[0];
`else
  assign id_tdo = 1'b0;
`endif

  // TDO source: IR LSB in ShIR, selected data register LSB in ShDR, quiet elsewhere.
  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_d    = (|(dr_sel & tap.dr_tdo)) | (sel_id & id_tdo) | (sel_byp & byp_q);
      tdo_en_d = 1'b1;
    end
  end

  // TDO launches on falling TCK so the far end can sample it on the next rising edge.
  always_ff @(negedge TCK or negedge TRST_b) begin
    if (!TRST_b) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tap.TDO       = tdo_q;
  assign tap.tdo_en    = tdo_en_q;
  assign tap.test_mode = test_mode_q;
  assign tap.inst      = inst_q;
  assign tap.dr_sel    = dr_sel;
  assign tap.capt_dr   = dr_sel & {N_DR{state_q == CAP_DR}};
  assign tap.shft_dr   = dr_sel & {N_DR{state_q == SH_DR}};
  assign tap.upd_dr    = dr_sel & {N_DR{state_q == UPD_DR}};

endmodule

// File: tb/tb_tap_gen2.sv
// tb_tap_gen2: directed TAP sequences checked every cycle against a queue-based model of the 1149.1 rules.
// Latency: model outputs compared half a TCK after each rising edge, TDO re-checked after the next rising edge.
// Backpressure: none; stimulus drives TMS/TDI/dr_tdo once per TCK period.
module tb_tap_gen2;
  localparam int          IR_W   = 4;
  localparam int          N_DR   = 2;
  localparam logic [31:0] ID_VAL = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam bit              HAS_ID       = 1'b1;
  localparam logic [IR_W-1:0] INST_RST     = 4'hE;
  localparam logic [31:0]     EXP_ID_SCAN  = 32'h1000_0001;
`else
  localparam bit              HAS_ID       = 1'b0;
  localparam logic [IR_W-1:0] INST_RST     = 4'hF;
  localparam logic [31:0]     EXP_ID_SCAN  = 32'h4B4A_1E1E;
`endif

  // Model state numbering: 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PsDR, 7 Ex2DR, 8 UpdDR,
  // 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PsIR, 14 Ex2IR, 15 UpdIR.
  localparam int S_TLR = 0, S_CAPDR = 3, S_SHDR = 4, S_UPDDR = 8;
  localparam int S_CAPIR = 10, S_SHIR = 11, S_UPDIR = 15;
  localparam int NX1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  localparam int NX0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};

  logic TCK = 1'b0;
  logic TRST_b = 1'b1;

  tap_gen2_if #(.IR_W(IR_W), .N_DR(N_DR)) io ();

  tap_gen2 #(
    .IR_W(IR_W), .N_DR(N_DR), .IDCODE_OP(4'hE), .IDCODE_VAL(ID_VAL)
  ) dut (
    .TCK(TCK), .TRST_b(TRST_b), .tap(io.slave)
  );

  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_fail = 0;

  int              m_st;
  logic [IR_W-1:0] m_inst;
  bit              m_irq[$];
  bit              m_drq[$];

  bit          chk_on = 1'b0;
  logic        exp_tdo = 1'b0;
  logic        exp_en = 1'b0;
  bit          use_dro = 1'b0;
  logic [31:0] dro_pat = '0;
  int cnt_capt1 = 0, cnt_shft1 = 0, cnt_upd1 = 0, cnt_ch0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int chain_of(input logic [IR_W-1:0] op);
    return (int'(op) < N_DR) ? int'(op) : -1;
  endfunction

  function automatic bit is_id(input logic [IR_W-1:0] op);
    return HAS_ID && (op == 4'hE);
  endfunction

  function automatic logic [N_DR-1:0] sel_of(input logic [IR_W-1:0] op);
    logic [N_DR-1:0] s;
    s = '0;
    if (chain_of(op) >= 0) s[chain_of(op)] = 1'b1;
    return s;
  endfunction

  function automatic logic model_tdo();
    if (m_st == S_SHIR) return m_irq[0];
    if (m_st == S_SHDR) begin
      if (chain_of(m_inst) >= 0) return io.dr_tdo[chain_of(m_inst)];
      return m_drq[0];
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st   = S_TLR;
    m_inst = INST_RST;
    m_irq.delete();
    m_irq.push_back(1'b1);
    for (int i = 1; i < IR_W; i++) m_irq.push_back(1'b0);
    m_drq.delete();
  endtask

  // One rising TCK as the standard describes it: act on the current state, then move.
  task automatic model_edge(input logic tms, input logic tdi);
    logic [IR_W-1:0] v;
    v = '0;
    case (m_st)
      S_TLR: m_inst = INST_RST;
      S_CAPIR: begin
        m_irq.delete();
        m_irq.push_back(1'b1);
        for (int i = 1; i < IR_W; i++) m_irq.push_back(1'b0);
      end
      S_SHIR: begin
        void'(m_irq.pop_front());
        m_irq.push_back(tdi);
      end
      S_UPDIR: begin
        for (int i = 0; i < IR_W; i++) v[i] = m_irq[i];
        m_inst = v;
      end
      S_CAPDR: begin
        if (chain_of(m_inst) < 0) begin
          m_drq.delete();
          if (is_id(m_inst)) begin
            for (int i = 0; i < 32; i++) m_drq.push_back(ID_VAL[i]);
          end else begin
            m_drq.push_back(1'b0);
          end
        end
      end
      S_SHDR: begin
        if (chain_of(m_inst) < 0) begin
          void'(m_drq.pop_front());
          m_drq.push_back(tdi);
        end
      end
      default: ;
    endcase
    m_st = tms ? NX1[m_st] : NX0[m_st];
  endtask

  // Compare process: all outputs half a period after each rising edge, TDO again just after the next rising edge.
  always begin
    logic [N_DR-1:0] es;
    logic [N_DR-1:0] z;
    @(negedge TCK);
    exp_tdo = model_tdo();
    exp_en  = (m_st == S_SHIR) || (m_st == S_SHDR);
    #1;
    if (chk_on) begin
      es = sel_of(m_inst);
      z  = '0;
      chk("test_mode", io.test_mode, m_st != S_TLR);
      chk("inst", io.inst, m_inst);
      chk("dr_sel", io.dr_sel, es);
      chk("capt_dr", io.capt_dr, (m_st == S_CAPDR) ? es : z);
      chk("shft_dr", io.shft_dr, (m_st == S_SHDR) ? es : z);
      chk("upd_dr", io.upd_dr, (m_st == S_UPDDR) ? es : z);
      chk("tdo_en", io.tdo_en, exp_en);
      chk("tdo", io.TDO, exp_tdo);
    end
    @(posedge TCK);
    #1;
    if (chk_on && TRST_b) begin
      chk("tdo_hold", io.TDO, exp_tdo);
      chk("tdo_en_hold", io.tdo_en, exp_en);
    end
  end

  task automatic tick(input logic tms, input logic tdi);
    io.TMS = tms;
    io.TDI = tdi;
    @(posedge TCK);
    model_edge(tms, tdi);
    @(negedge TCK);
    #2;
    cnt_capt1 += int'(io.capt_dr[1]);
    cnt_shft1 += int'(io.shft_dr[1]);
    cnt_upd1  += int'(io.upd_dr[1]);
    cnt_ch0   += int'(io.capt_dr[0] | io.shft_dr[0] | io.upd_dr[0]);
  endtask

  task automatic set_dro(input int r);
    io.dr_tdo = use_dro ? {dro_pat[r], ~dro_pat[r]} : 2'b00;
  endtask

  // From RTI: full DR scan of n bits, returning TDO bits LSB first; ends in RTI.
  task automatic scan_dr(input int n, input logic [31:0] tdi_bits, output logic [31:0] got);
    got = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    set_dro(0);
    tick(1'b0, 1'b0);
    got[0] = io.TDO;
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) set_dro(i + 1);
      tick(i == n - 1, tdi_bits[i]);
      if (i < n - 1) got[i + 1] = io.TDO;
    end
    io.dr_tdo = 2'b00;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From RTI: load an instruction, returning the TDO bits seen in ShIR; ends in RTI.
  task automatic load_ir(input logic [IR_W-1:0] op, output logic [IR_W-1:0] got);
    got = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    got[0] = io.TDO;
    for (int i = 0; i < IR_W; i++) begin
      tick(i == IR_W - 1, op[i]);
      if (i < IR_W - 1) got[i + 1] = io.TDO;
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // Called at negedge+2: assert TRST_b mid-period; caller checks, then release_reset.
  task automatic assert_reset();
    #1;
    TRST_b = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge TCK);
    #2;
    TRST_b = 1'b1;
    @(negedge TCK);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inst"}, io.inst, INST_RST);
    chk({tag, "_tdo"}, io.TDO, 1'b0);
    chk({tag, "_tdo_en"}, io.tdo_en, 1'b0);
    chk({tag, "_test_mode"}, io.test_mode, 1'b0);
    chk({tag, "_dr_sel"}, io.dr_sel, 2'b00);
    chk({tag, "_shft_dr"}, io.shft_dr, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]     got32;
    logic [IR_W-1:0] got_ir;
    io.TMS    = 1'b1;
    io.TDI    = 1'b0;
    io.dr_tdo = 2'b00;

    // Power-on reset.
    #2;
    TRST_b = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("por");
    @(posedge TCK);
    #2;
    TRST_b = 1'b1;
    @(negedge TCK);
    #2;
    chk_on = 1'b1;

    // Reset instruction straight into a 32-bit DR scan.
    tick(1'b0, 1'b0);
    scan_dr(32, 32'hA5A5_0F0F, got32);
    chk("id_scan", got32, EXP_ID_SCAN);

    // IR capture pattern while loading BYPASS.
    load_ir(4'hF, got_ir);
    chk("ir_capture", got_ir, 4'b0001);
    chk("inst_bypass", io.inst, 4'hF);

    // One-bit bypass delay.
    scan_dr(8, 32'h4D, got32);
    chk("bypass_scan", got32[7:0], 8'h9A);

    // DR scan through the pause states.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // External chain 1: strobes and TDO steering.
    load_ir(4'h1, got_ir);
    chk("dr_sel_chain1", io.dr_sel, 2'b10);
    cnt_capt1 = 0; cnt_shft1 = 0; cnt_upd1 = 0; cnt_ch0 = 0;
    use_dro = 1'b1;
    dro_pat = 32'hC5;
    scan_dr(8, 32'h3C, got32);
    chk("chain1_tdo", got32[7:0], 8'hC5);
    chk("chain1_capt_periods", cnt_capt1, 1);
    chk("chain1_shft_periods", cnt_shft1, 8);
    chk("chain1_upd_periods", cnt_upd1, 1);
    chk("chain0_strobes", cnt_ch0, 0);

    // External chain 0 gets the inverted pattern.
    load_ir(4'h0, got_ir);
    chk("dr_sel_chain0", io.dr_sel, 2'b01);
    scan_dr(4, 32'h5, got32);
    chk("chain0_tdo", got32[3:0], 4'hA);
    use_dro = 1'b0;

    // Five TMS=1 edges from ShDR reach TLR; the sixth holds it.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 1'b0);
      chk($sformatf("tms5_test_mode_%0d", i), io.test_mode, i < 5);
    end
    chk("tms5_inst", io.inst, INST_RST);

    // TRST_b mid-ShDR on chain 1.
    tick(1'b0, 1'b0);
    load_ir(4'h1, got_ir);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    io.dr_tdo = 2'b11;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("pre_rst_tdo", io.TDO, 1'b1);
    chk("pre_rst_tdo_en", io.tdo_en, 1'b1);
    assert_reset();
    chk_reset_outputs("rst_shdr");
    release_reset();
    io.dr_tdo = 2'b00;

    // TRST_b mid-ShIR discards the partial instruction.
    tick(1'b0, 1'b0);
    load_ir(4'h0, got_ir);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    assert_reset();
    chk_reset_outputs("rst_shir");
    release_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("post_rst_inst", io.inst, INST_RST);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
